// File: rtl/matrix_link_pkg.sv
// Shared encodings for the matrix link controller: FSM states, error codes,
// and the bytes-per-element width helper.
package matrix_link_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RX_A    = 3'd1,
      S_RX_B    = 3'd2,
      S_COMPUTE = 3'd3,
      S_TX_RES  = 3'd4,
      S_TX_ERR  = 3'd5
   } state_t;

   localparam logic [7:0] ERR_SIZE    = 8'hE0;
   localparam logic [7:0] ERR_TIMEOUT = 8'hEE;

   function automatic int unsigned bytes_per(input int unsigned w);
      return (w + 7) / 8;
   endfunction

endpackage

// File: rtl/matrix_link_ctrl_byte_serializer.sv
// Walks the captured result row-major, LSB byte first, and hands bytes to the
// transmitter one strobe at a time; in error mode it sends the single error code.
module byte_serializer
   import matrix_link_pkg::*;
#(
   parameter int MAX_N = 3,
   parameter int RES_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         err_mode,
   input  logic [7:0]                   err_code,
   input  logic [3:0]                   n,
   input  logic [MAX_N*MAX_N*RES_W-1:0] res,
   input  logic                         tx_busy,
   output logic [7:0]                   tx_data,
   output logic                         tx_start,
   output logic                         fire,
   output logic                         last
);
   localparam int RB = int'(bytes_per(RES_W));
   localparam logic [2:0] RB_LAST = 3'(RB - 1);

   logic [3:0]      row_q, col_q, n_last;
   logic [2:0]      bi_q;
   logic            hold_q;
   int              idx;
   logic [RB*8-1:0] elem_wide;
   logic [7:0]      byte_d;

   always_comb begin
      n_last    = n - 4'd1;
      idx       = int'(row_q) * MAX_N + int'(col_q);
      elem_wide = '0;
      elem_wide[RES_W-1:0] = res[idx*RES_W +: RES_W];
      byte_d    = err_mode ? err_code : elem_wide[int'(bi_q)*8 +: 8];
      last      = err_mode || ((bi_q == RB_LAST) && (col_q == n_last) && (row_q == n_last));
      // The transmitter may not raise busy until the cycle after our strobe.
      fire      = en && !tx_busy && !hold_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_data  <= 8'd0;
         tx_start <= 1'b0;
         hold_q   <= 1'b0;
         row_q    <= 4'd0;
         col_q    <= 4'd0;
         bi_q     <= 3'd0;
      end else begin
         tx_start <= fire;
         hold_q   <= fire;
         if (fire) tx_data <= byte_d;
         if (!en) begin
            row_q <= 4'd0;
            col_q <= 4'd0;
            bi_q  <= 3'd0;
         end else if (fire && !last) begin
            if (bi_q != RB_LAST) begin
               bi_q <= bi_q + 3'd1;
            end else begin
               bi_q <= 3'd0;
               if (col_q == n_last) begin
                  col_q <= 4'd0;
                  row_q <= row_q + 4'd1;
               end else begin
                  col_q <= col_q + 4'd1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/matrix_link_ctrl.sv
// Byte-link front end for a matrix multiplier: receives n, A and B, launches the
// multiply, and streams the result (or an error code) back over the link.
module matrix_link_ctrl
   import matrix_link_pkg::*;
#(
   parameter int MAX_N   = 3,
   parameter int DATA_W  = 8,
   parameter int RES_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_valid,
   input  logic                          tx_busy,
   output logic [7:0]                    tx_data,
   output logic                          tx_start,
   output logic                          mult_start,
   input  logic                          mult_done,
   input  logic [MAX_N*MAX_N*RES_W-1:0]  res_flat,
   output logic [MAX_N*MAX_N*DATA_W-1:0] a_flat,
   output logic [MAX_N*MAX_N*DATA_W-1:0] b_flat,
   output logic [3:0]                    n_size,
   output logic [2:0]                    state,
   output logic                          rx_drop
);
   localparam int DB = int'(bytes_per(DATA_W));
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [2:0]    DB_LAST  = 3'(DB - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_t                       state_q, state_d;
   logic [3:0]                   row_q, col_q, n_last;
   logic [2:0]                   bi_q;
   logic [TW-1:0]                tmo_q;
   logic [7:0]                   err_q;
   logic [MAX_N*MAX_N*RES_W-1:0] res_q;
   logic [DB*8-1:0]              elem_wide;
   logic                         rx_take, byte_last, elem_last, mat_last, size_ok;
   logic                         ser_en, ser_err, ser_fire, ser_last;
   int                           idx;

   assign state   = state_q;
   assign ser_en  = (state_q == S_TX_RES) || (state_q == S_TX_ERR);
   assign ser_err = (state_q == S_TX_ERR);

   always_comb begin
      n_last    = n_size - 4'd1;
      rx_take   = rx_valid && ((state_q == S_RX_A) || (state_q == S_RX_B));
      byte_last = (bi_q == DB_LAST);
      elem_last = (col_q == n_last);
      mat_last  = byte_last && elem_last && (row_q == n_last);
      size_ok   = (rx_data != 8'd0) && (rx_data <= 8'(MAX_N));
      idx       = int'(row_q) * MAX_N + int'(col_q);
      // Merge the incoming byte into the element; bits above DATA_W fall away.
      elem_wide = '0;
      if (state_q == S_RX_B) elem_wide[DATA_W-1:0] = b_flat[idx*DATA_W +: DATA_W];
      else                   elem_wide[DATA_W-1:0] = a_flat[idx*DATA_W +: DATA_W];
      elem_wide[int'(bi_q)*8 +: 8] = rx_data;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (rx_valid) state_d = size_ok ? S_RX_A : S_TX_ERR;
         S_RX_A:    if (rx_take && mat_last) state_d = S_RX_B;
         S_RX_B:    if (rx_take && mat_last) state_d = S_COMPUTE;
         S_COMPUTE: begin
            if (mult_done)              state_d = S_TX_RES;
            else if (tmo_q == TMO_LAST) state_d = S_TX_ERR;
         end
         S_TX_RES, S_TX_ERR: if (ser_fire && ser_last) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         mult_start <= 1'b0;
         n_size     <= 4'd0;
         rx_drop    <= 1'b0;
         a_flat     <= '0;
         b_flat     <= '0;
         row_q      <= 4'd0;
         col_q      <= 4'd0;
         bi_q       <= 3'd0;
         tmo_q      <= '0;
         err_q      <= 8'd0;
         res_q      <= '0;
      end else begin
         state_q    <= state_d;
         mult_start <= (state_q == S_RX_B) && (state_d == S_COMPUTE);
         tmo_q      <= '0;
         case (state_q)
            S_IDLE: if (rx_valid) begin
               if (size_ok) begin
                  n_size  <= rx_data[3:0];
                  rx_drop <= 1'b0;
                  a_flat  <= '0;
                  b_flat  <= '0;
                  row_q   <= 4'd0;
                  col_q   <= 4'd0;
                  bi_q    <= 3'd0;
               end else begin
                  err_q <= ERR_SIZE;
               end
            end
            S_RX_A, S_RX_B: if (rx_valid) begin
               if (state_q == S_RX_A) a_flat[idx*DATA_W +: DATA_W] <= elem_wide[DATA_W-1:0];
               else                   b_flat[idx*DATA_W +: DATA_W] <= elem_wide[DATA_W-1:0];
               if (!byte_last) begin
                  bi_q <= bi_q + 3'd1;
               end else begin
                  bi_q <= 3'd0;
                  if (mat_last) begin
                     row_q <= 4'd0;
                     col_q <= 4'd0;
                  end else if (elem_last) begin
                     row_q <= row_q + 4'd1;
                     col_q <= 4'd0;
                  end else begin
                     col_q <= col_q + 4'd1;
                  end
               end
            end
            S_COMPUTE: begin
               if (rx_valid) rx_drop <= 1'b1;
               if (mult_done)              res_q <= res_flat;
               else if (tmo_q == TMO_LAST) err_q <= ERR_TIMEOUT;
               else                        tmo_q <= tmo_q + TW'(1);
            end
            default: if (rx_valid) rx_drop <= 1'b1;
         endcase
      end
   end

   byte_serializer #(
      .MAX_N (MAX_N),
      .RES_W (RES_W)
   ) u_ser (
      .clk      (clk),
      .rst      (rst),
      .en       (ser_en),
      .err_mode (ser_err),
      .err_code (err_q),
      .n        (n_size),
      .res      (res_q),
      .tx_busy  (tx_busy),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .fire     (ser_fire),
      .last     (ser_last)
   );

endmodule
